hazard_fwd_unit: RTL and testbench
==================================

HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
REQ-001 The block SHALL have the port `clk`, input, 1 bit: the single pipeline clock, rising-edge active.
REQ-002 The block SHALL have the port `rst_n`, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the ports `id_rs1` and `id_rs2`, input, 5 bits each: the source register indices of the instruction in ID.
REQ-004 The block SHALL have the ports `id_rs1_used` and `id_rs2_used`, input, 1 bit each: the corresponding source register is actually read.
REQ-005 The block SHALL have the ports `id_rd` (input, 5 bits), `id_regwrite` (input, 1 bit) and `id_memread` (input, 1 bit): destination index, register-write flag and load flag of the instruction in ID.
REQ-006 The block SHALL have the port `id_valid`, input, 1 bit: the IF/ID register holds a real instruction.
REQ-007 The block SHALL have the port `ex_branch_taken`, input, 1 bit: the branch or jump resolved in EX redirects the PC this cycle.
REQ-008 The block SHALL have the ports `fwd_a_sel` and `fwd_b_sel`, output, 2 bits each: the select for the EX-stage 3:1 operand mux, encoded 00 = register-file value, 01 = EX/MEM result, 10 = MEM/WB result; 11 is never driven.
REQ-009 The block SHALL have the ports `pc_write` and `ifid_write`, output, 1 bit each: enables for the PC and the IF/ID register.
REQ-010 The block SHALL have the ports `idex_bubble` and `ifid_flush`, output, 1 bit each: insert a NOP into ID/EX, and clear IF/ID.
REQ-011 The block SHALL have the port `stall_count`, output, 32 bits: the number of cycles with `pc_write` = 0.

Function
REQ-012 The block SHALL keep shadow pipeline registers:
- EXs: rs1, rs2, used flags, rd, regwrite, memread.
- MEMs: rd, regwrite.
- WBs: rd, regwrite.
REQ-013 The shadow registers SHALL advance every rising edge:
- MEMs <= EXs.
- WBs <= MEMs.
- EXs <= ID inputs, or a bubble (all flags 0) when `idex_bubble` = 1 or `id_valid` = 0.
REQ-014 `fwd_a_sel` SHALL be computed combinationally from EXs.rs1, with EX/MEM taking priority over MEM/WB:
- 01 if MEMs.regwrite = 1, MEMs.rd != 0 and MEMs.rd = EXs.rs1.
- else 10 if WBs.regwrite = 1, WBs.rd != 0 and WBs.rd = EXs.rs1.
- else 00.
REQ-015 `fwd_b_sel` SHALL be computed identically to REQ-014 using EXs.rs2.
REQ-016 A hazard SHALL be detected in a cycle when all of the following hold:
- EXs.memread = 1 and EXs.rd != 0.
- `id_valid` = 1.
- (id_rs1_used = 1 and id_rs1 = EXs.rd) or (id_rs2_used = 1 and id_rs2 = EXs.rd).
REQ-017 The stall FSM SHALL have the states RUN and STALL, reset to RUN.
REQ-018 In RUN with a hazard detected, the block SHALL drive `pc_write` = 0, `ifid_write` = 0 and `idex_bubble` = 1 in the same cycle and move to STALL.
REQ-019 In STALL, the injected bubble has cleared EXs, so the block SHALL return to RUN unless a new hazard is detected.
REQ-020 In RUN with no hazard, the block SHALL drive `pc_write` = 1, `ifid_write` = 1, `idex_bubble` = 0 and `ifid_flush` = 0.
REQ-021 When `ex_branch_taken` = 1, the block SHALL drive `ifid_flush` = 1, `idex_bubble` = 1 and `pc_write` = 1 in the same cycle, suppress any stall, and force the FSM to RUN; flush has priority over stall.
REQ-022 A register index of 0 SHALL never cause forwarding or a stall.
REQ-023 `stall_count` SHALL increment by 1 on every edge where `pc_write` = 0, wrap from 0xFFFFFFFF to 0, and never saturate.

Reset
REQ-024 While `rst_n` = 0, the block SHALL asynchronously clear all shadow registers to 0, put the FSM in RUN and clear `stall_count` to 0.
REQ-025 While `rst_n` = 0, the outputs SHALL be `fwd_a_sel` = 00, `fwd_b_sel` = 00, `pc_write` = 1, `ifid_write` = 1, `idex_bubble` = 0 and `ifid_flush` = 0.
REQ-026 A reset asserted during STALL SHALL abandon the stall; after release the block SHALL behave as if it had come out of a cold reset.
REQ-027 The release of `rst_n` SHALL take effect at the first rising edge of `clk` after deassertion.

Configuration
REQ-028 With the macro `HAZARD_FWD_EN` defined, the block SHALL implement forwarding exactly as in REQ-014 and REQ-015.
REQ-029 Without `HAZARD_FWD_EN`, `fwd_a_sel` and `fwd_b_sel` SHALL be tied to 00.
REQ-030 Without `HAZARD_FWD_EN`, the hazard condition SHALL also be met by any matching writer in EXs or MEMs with regwrite = 1 and rd != 0, so the block stalls until that writer reaches WB; the register file writes in the first half-cycle, so WB is never a hazard.
REQ-031 Without `HAZARD_FWD_EN`, the FSM SHALL hold STALL for as many consecutive cycles as the hazard persists, up to 2.

Verification
REQ-032 The bench SHALL cover back-to-back ALU forwarding: add x5 then sub x6,x5,x1 -> `fwd_a_sel` = 01 in the cycle the sub is in EX; no stall.
REQ-033 The bench SHALL cover 2-apart forwarding with priority: writers to x7 at distance 1 and 2, then a reader of x7 -> sel = 01 (EX/MEM wins); with only the distance-2 writer -> sel = 10.
REQ-034 The bench SHALL cover load-use: lw x8, then add x9,x8,x8 -> exactly one cycle with `pc_write` = 0 and `idex_bubble` = 1; then `fwd_a_sel` = `fwd_b_sel` = 10; `stall_count` = 1.
REQ-035 The bench SHALL cover the x0 rule: lw x0, then a reader of x0 -> no stall, sel = 00.
REQ-036 The bench SHALL cover flush over stall: a load-use hazard with `ex_branch_taken` = 1 in the same cycle -> `ifid_flush` = 1, `pc_write` = 1, `stall_count` unchanged.
REQ-037 The bench SHALL cover reset mid-stall and the build without `HAZARD_FWD_EN`:
- Assert `rst_n` = 0 during STALL -> outputs take their reset values immediately; `stall_count` = 0.
- Without `HAZARD_FWD_EN`, add x5 then a reader of x5 -> 2 stall cycles; sel stays 00.

Source files
------------

// File: rtl/hazard_fwd_unit.sv
`default_nettype none
// ==========================================================================
// hazard_fwd_unit : load-use stall, branch flush and EX operand forwarding.
// HAZARD_FWD_EN enables forwarding; without it RAW hazards stall. Rev 1.0
// ==========================================================================
module hazard_fwd_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  id_rd,
  input  logic        id_regwrite,
  input  logic        id_memread,
  input  logic        id_valid,
  input  logic        ex_branch_taken,
  output logic [1:0]  fwd_a_sel,
  output logic [1:0]  fwd_b_sel,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idex_bubble,
  output logic        ifid_flush,
  output logic [31:0] stall_count
);

  typedef enum logic [0:0] {RUN = 1'b0, STALL = 1'b1} state_t;

`ifdef HAZARD_FWD_EN
  localparam logic [1:0] MAX_STALL = 2'd1;
`else
  localparam logic [1:0] MAX_STALL = 2'd2;
`endif

  state_t      r_state;
  logic        r_stall_len;
  logic [4:0]  r_ex_rd;
  logic        r_ex_regwrite;
  logic        r_ex_memread;
  logic [4:0]  r_mem_rd;
  logic        r_mem_regwrite;
  logic [31:0] r_stall_count;

  logic        w_ex_match;
  logic        w_hazard;
  logic        w_stall;
  logic        w_bubble;

  assign w_ex_match = (r_ex_rd != 5'd0) &&
                      ((id_rs1_used && (id_rs1 == r_ex_rd)) ||
                       (id_rs2_used && (id_rs2 == r_ex_rd)));

`ifdef HAZARD_FWD_EN
  logic [4:0] r_ex_rs1;
  logic [4:0] r_ex_rs2;
  logic [4:0] r_wb_rd;
  logic       r_wb_regwrite;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic mem_rw, input logic [4:0] mem_rd,
                                         input logic wb_rw,  input logic [4:0] wb_rd);
    if (mem_rw && (mem_rd != 5'd0) && (mem_rd == rs))
      return 2'b01;
    else if (wb_rw && (wb_rd != 5'd0) && (wb_rd == rs))
      return 2'b10;
    else
      return 2'b00;
  endfunction

  assign fwd_a_sel = fwd_sel(r_ex_rs1, r_mem_regwrite, r_mem_rd, r_wb_regwrite, r_wb_rd);
  assign fwd_b_sel = fwd_sel(r_ex_rs2, r_mem_regwrite, r_mem_rd, r_wb_regwrite, r_wb_rd);
  assign w_hazard  = id_valid && r_ex_memread && w_ex_match;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_rs1      <= 5'd0;
      r_ex_rs2      <= 5'd0;
      r_wb_rd       <= 5'd0;
      r_wb_regwrite <= 1'b0;
    end else begin
      r_ex_rs1      <= w_bubble ? 5'd0 : id_rs1;
      r_ex_rs2      <= w_bubble ? 5'd0 : id_rs2;
      r_wb_rd       <= r_mem_rd;
      r_wb_regwrite <= r_mem_regwrite;
    end
  end
`else
  logic w_mem_match;

  // Register file writes in the first half-cycle, so only EX and MEM writers conflict.
  assign w_mem_match = (r_mem_rd != 5'd0) &&
                       ((id_rs1_used && (id_rs1 == r_mem_rd)) ||
                        (id_rs2_used && (id_rs2 == r_mem_rd)));
  assign fwd_a_sel   = 2'b00;
  assign fwd_b_sel   = 2'b00;
  assign w_hazard    = id_valid &&
                       (((r_ex_memread || r_ex_regwrite) && w_ex_match) ||
                        (r_mem_regwrite && w_mem_match));
`endif

  assign w_stall  = w_hazard &&
                    !((r_state == STALL) && (({1'b0, r_stall_len} + 2'd1) == MAX_STALL));
  assign w_bubble = idex_bubble || !id_valid;

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    if (!rst_n) begin
      pc_write = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (w_stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_rd        <= 5'd0;
      r_ex_regwrite  <= 1'b0;
      r_ex_memread   <= 1'b0;
      r_mem_rd       <= 5'd0;
      r_mem_regwrite <= 1'b0;
    end else begin
      r_ex_rd        <= w_bubble ? 5'd0 : id_rd;
      r_ex_regwrite  <= w_bubble ? 1'b0 : id_regwrite;
      r_ex_memread   <= w_bubble ? 1'b0 : id_memread;
      r_mem_rd       <= r_ex_rd;
      r_mem_regwrite <= r_ex_regwrite;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= RUN;
      r_stall_len   <= 1'b0;
      r_stall_count <= 32'd0;
    end else begin
      if (!pc_write)
        r_stall_count <= r_stall_count + 32'd1;
      if (ex_branch_taken || !w_stall) begin
        r_state     <= RUN;
        r_stall_len <= 1'b0;
      end else if (r_state == RUN) begin
        r_state     <= STALL;
        r_stall_len <= 1'b0;
      end else begin
        r_stall_len <= 1'b1;
      end
    end
  end

  assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_hazard_fwd_unit.sv
`default_nettype none
// ==========================================================================
// tb_hazard_fwd_unit : directed per-cycle vectors for hazard_fwd_unit.
// Expectations follow HAZARD_FWD_EN when defined. Rev 1.0
// ==========================================================================
module tb_hazard_fwd_unit;

  logic        clk;
  logic        rst_n;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_rs1_used, id_rs2_used, id_regwrite, id_memread, id_valid;
  logic        ex_branch_taken;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        pc_write, ifid_write, idex_bubble, ifid_flush;
  logic [31:0] stall_count;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_fwd_unit dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_valid(id_valid), .ex_branch_taken(ex_branch_taken),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .pc_write(pc_write), .ifid_write(ifid_write),
    .idex_bubble(idex_bubble), .ifid_flush(ifid_flush),
    .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2, rw, mr, valid, br;
    logic [1:0]  a, b;
    logic        pcw, bub, fl;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[$];

`ifdef HAZARD_FWD_EN
  localparam int CNT_BEFORE_RST = 1;
`else
  localparam int CNT_BEFORE_RST = 5;
`endif

  task automatic add_vec(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                         input logic u2, input logic [4:0] rd, input logic rw,
                         input logic mr, input logic valid, input logic br,
                         input logic [1:0] a, input logic [1:0] b, input logic pcw,
                         input logic bub, input logic fl, input int cnt);
    vec_t v;
    v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2; v.rd = rd; v.rw = rw;
    v.mr = mr; v.valid = valid; v.br = br; v.a = a; v.b = b;
    v.pcw = pcw; v.bub = bub; v.fl = fl; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                       input logic u2, input logic [4:0] rd, input logic rw,
                       input logic mr, input logic valid, input logic br);
    id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_rd = rd; id_regwrite = rw; id_memread = mr; id_valid = valid;
    ex_branch_taken = br;
  endtask

  function automatic logic [39:0] outs();
    return {fwd_a_sel, fwd_b_sel, pc_write, ifid_write, idex_bubble, ifid_flush, stall_count};
  endfunction

  function automatic logic [39:0] expv(input logic [1:0] a, input logic [1:0] b,
                                       input logic pcw, input logic bub, input logic fl,
                                       input int cnt);
    return {a, b, pcw, pcw, bub, fl, cnt[31:0]};
  endfunction

  task automatic check(input string name, input logic [39:0] got, input logic [39:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got a/b/pcw/ifw/bub/fl/cnt=%h, required %h", name, got, exp);
    end
  endtask

  initial begin
    // Reset: outputs idle even with a branch and a valid instruction present.
    rst_n = 1'b0;
    drive(5'd8, 1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1);
    #1;
    check("reset_outputs", outs(), expv(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 0));
    @(negedge clk);
    @(negedge clk);
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

`ifdef HAZARD_FWD_EN
    add_vec(1,1, 2,1,  5,1,0,1,0, 0,0,1,0,0,0);   // add x5
    add_vec(5,1, 1,1,  6,1,0,1,0, 0,0,1,0,0,0);   // sub x6,x5,x1
    add_vec(0,0, 0,0,  0,0,0,1,0, 1,0,1,0,0,0);   // sub in EX: EX/MEM fwd
    add_vec(0,0, 0,0,  7,1,0,1,0, 0,0,1,0,0,0);   // writer x7
    add_vec(0,0, 0,0,  7,1,0,1,0, 0,0,1,0,0,0);   // writer x7
    add_vec(7,1, 7,1, 10,1,0,1,0, 0,0,1,0,0,0);   // reader x7
    add_vec(0,0, 0,0,  0,0,0,1,0, 1,1,1,0,0,0);   // EX/MEM wins over MEM/WB
    add_vec(0,0, 0,0,  7,1,0,1,0, 0,0,1,0,0,0);   // writer x7
    add_vec(0,0, 0,0,  0,0,0,1,0, 0,0,1,0,0,0);
    add_vec(7,1, 0,1, 11,1,0,1,0, 0,0,1,0,0,0);   // reader x7, x0
    add_vec(0,0, 0,0,  0,0,0,1,0, 2,0,1,0,0,0);   // MEM/WB only
    add_vec(1,1, 0,0,  8,1,1,1,0, 0,0,1,0,0,0);   // lw x8
    add_vec(8,1, 8,1,  9,1,0,1,0, 0,0,0,1,0,0);   // add x9,x8,x8: stall
    add_vec(8,1, 8,1,  9,1,0,1,0, 0,0,1,0,0,1);   // held, released
    add_vec(0,0, 0,0,  0,0,0,1,0, 2,2,1,0,0,1);   // add in EX: MEM/WB fwd
    add_vec(1,1, 0,0,  0,1,1,1,0, 0,0,1,0,0,1);   // lw x0
    add_vec(0,1, 0,1, 12,1,0,1,0, 0,0,1,0,0,1);   // reader x0: no stall
    add_vec(0,0, 0,0,  0,0,0,1,0, 0,0,1,0,0,1);   // no fwd of x0
    add_vec(1,1, 0,0, 13,1,1,1,0, 0,0,1,0,0,1);   // lw x13
    add_vec(13,1,0,0, 14,1,0,1,1, 0,0,1,1,1,1);   // load-use + branch: flush
    add_vec(0,0, 0,0,  0,0,0,0,0, 0,0,1,0,0,1);   // count unchanged
`else
    add_vec(1,1, 2,1,  5,1,0,1,0, 0,0,1,0,0,0);   // add x5
    add_vec(5,1, 1,1,  6,1,0,1,0, 0,0,0,1,0,0);   // reader x5: stall 1
    add_vec(5,1, 1,1,  6,1,0,1,0, 0,0,0,1,0,1);   // stall 2
    add_vec(5,1, 1,1,  6,1,0,1,0, 0,0,1,0,0,2);   // writer in WB: go
    add_vec(0,0, 0,0,  0,0,0,1,0, 0,0,1,0,0,2);
    add_vec(1,1, 0,0,  8,1,1,1,0, 0,0,1,0,0,2);   // lw x8
    add_vec(8,1, 8,1,  9,1,0,1,0, 0,0,0,1,0,2);   // load-use: stall 1
    add_vec(8,1, 8,1,  9,1,0,1,0, 0,0,0,1,0,3);   // stall 2
    add_vec(8,1, 8,1,  9,1,0,1,0, 0,0,1,0,0,4);
    add_vec(1,1, 0,0,  0,1,1,1,0, 0,0,1,0,0,4);   // lw x0
    add_vec(0,1, 0,1, 12,1,0,1,0, 0,0,1,0,0,4);   // reader x0: no stall
    add_vec(0,0, 0,0,  0,0,0,1,0, 0,0,1,0,0,4);
    add_vec(1,1, 0,0, 13,1,1,1,0, 0,0,1,0,0,4);   // lw x13
    add_vec(13,1,0,0, 14,1,0,1,1, 0,0,1,1,1,4);   // hazard + branch: flush
    add_vec(0,0, 0,0,  0,0,0,0,0, 0,0,1,0,0,4);   // count unchanged
    add_vec(0,0, 0,0,  7,1,0,1,0, 0,0,1,0,0,4);   // writer x7
    add_vec(0,0, 0,0,  0,0,0,1,0, 0,0,1,0,0,4);
    add_vec(7,1, 0,0, 11,1,0,1,0, 0,0,0,1,0,4);   // writer in MEM: one stall
    add_vec(7,1, 0,0, 11,1,0,1,0, 0,0,1,0,0,5);
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].rs1, tbl[i].u1, tbl[i].rs2, tbl[i].u2, tbl[i].rd,
            tbl[i].rw, tbl[i].mr, tbl[i].valid, tbl[i].br);
      #1;
      check($sformatf("vec%0d", i), outs(),
            expv(tbl[i].a, tbl[i].b, tbl[i].pcw, tbl[i].bub, tbl[i].fl, int'(tbl[i].cnt)));
    end

    // Reset asserted in the middle of a load-use stall.
    @(negedge clk);
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    check("rst_seq_lw", outs(), expv(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, CNT_BEFORE_RST));
    @(negedge clk);
    drive(5'd8, 1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    check("rst_seq_stall", outs(), expv(2'b00, 2'b00, 1'b0, 1'b1, 1'b0, CNT_BEFORE_RST));
    rst_n = 1'b0;
    #1;
    check("rst_mid_stall", outs(), expv(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 0));
    ex_branch_taken = 1'b1;
    #1;
    check("rst_branch_masked", outs(), expv(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 0));
    @(negedge clk);
    ex_branch_taken = 1'b0;
    rst_n = 1'b1;
    #1;
    check("post_rst_cold", outs(), expv(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 0));
    @(negedge clk);
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    check("post_rst_run", outs(), expv(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
